// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant IDs, bus widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEA_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/ready memory handshake bundle; the requester side is the master modport.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [WEA_W-1:0]  wea;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, wea, addr, wdata, input rdata, ready);
  modport slave  (input req, we, wea, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_arb_watchdog: counts unanswered BUSY cycles and flags the last permitted one.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic m_ready,
  output logic expire
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !m_ready) begin
      count <= count + CNT_W'(1);
    end
  end

  // A same-cycle m_ready always beats the abort.
  assign expire = enable && !m_ready && (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU fetch and data accesses onto one memory handshake.
// Optional macro MEM_PORT_ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  i_bus,
  mem_port_arbiter_if.slave  d_bus,
  mem_port_arbiter_if.master m_bus,
  output logic               stall,
  output logic               err
);
  arb_state_t state, state_nx;
  grant_t     last_grant, win;
  logic       any_req, grant_go, busy, expire;
  logic       m_req, i_ready, d_ready;
  logic       err_flag;

  logic [ADDR_W-1:0] req_addr_p1;
  logic              req_we_p1;
  logic [WEA_W-1:0]  req_wea_p1;
  logic [DATA_W-1:0] req_wdata_p1;
  logic [DATA_W-1:0] rdata_p2;

  // The fetch port never writes; its write fields are intentionally ignored.
  logic unused_i_fields;
  assign unused_i_fields = ^{i_bus.we, i_bus.wea, i_bus.wdata};

  assign any_req  = i_bus.req || d_bus.req;
  assign grant_go = (state == IDLE) && any_req;
  assign busy     = (state == I_BUSY) || (state == D_BUSY);

  always_comb begin
    win = GRANT_D;
    if (i_bus.req && !d_bus.req) win = GRANT_I;
`ifdef MEM_PORT_ARB_RR_EN
    else if (i_bus.req && d_bus.req) win = other_grant(last_grant);
`endif
  end

`ifndef MEM_PORT_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m_req    = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = (win == GRANT_D) ? D_BUSY : I_BUSY;
      end
      I_BUSY: begin
        m_req = 1'b1;
        if (m_bus.ready || expire) state_nx = I_DONE;
      end
      D_BUSY: begin
        m_req = 1'b1;
        if (m_bus.ready || expire) state_nx = D_DONE;
      end
      I_DONE: begin
        i_ready  = 1'b1;
        state_nx = IDLE;
      end
      D_DONE: begin
        d_ready  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_go),
    .enable  (busy),
    .m_ready (m_bus.ready),
    .expire  (expire)
  );

  // Stage p1: winner's request latched on the IDLE->BUSY transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_p1  <= '0;
      req_we_p1    <= 1'b0;
      req_wea_p1   <= '0;
      req_wdata_p1 <= '0;
      last_grant   <= GRANT_I;
    end else if (grant_go) begin
      last_grant <= win;
      if (win == GRANT_D) begin
        req_addr_p1  <= d_bus.addr;
        req_we_p1    <= d_bus.we;
        req_wea_p1   <= d_bus.wea;
        req_wdata_p1 <= d_bus.wdata;
      end else begin
        req_addr_p1  <= i_bus.addr;
        req_we_p1    <= 1'b0;
        req_wea_p1   <= '0;
        req_wdata_p1 <= '0;
      end
    end
  end

  // Stage p2: returned word (zero on abort) and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p2 <= '0;
      err_flag <= 1'b0;
    end else if (busy && m_bus.ready) begin
      rdata_p2 <= m_bus.rdata;
    end else if (expire) begin
      rdata_p2 <= '0;
      err_flag <= 1'b1;
    end
  end

  assign m_bus.req   = m_req;
  assign m_bus.we    = req_we_p1;
  assign m_bus.wea   = req_wea_p1;
  assign m_bus.addr  = req_addr_p1;
  assign m_bus.wdata = req_wdata_p1;

  assign i_bus.ready = i_ready;
  assign i_bus.rdata = rdata_p2;
  assign d_bus.ready = d_ready;
  assign d_bus.rdata = rdata_p2;

  assign stall = (i_bus.req && !i_ready) || (d_bus.req && !d_ready);
  assign err   = err_flag;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic against a memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic stall, err;
  always #5 clk = ~clk;

  mem_port_arbiter_if i_bus ();
  mem_port_arbiter_if d_bus ();
  mem_port_arbiter_if m_bus ();

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus),
    .stall (stall),
    .err   (err)
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        i_exp[$];
  exp_t        d_exp[$];
  int          m_log[$];
  int          last_win = 0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mem[logic [31:0]];
  bit          mute = 1'b0;
  bit          stray_req = 1'b0;
  int          fixed_lat = 0;
  bit          i_pend_v = 1'b0, d_pend_v = 1'b0;
  logic [31:0] i_pend_a, d_pend_a, d_pend_wd;
  logic        d_pend_we;
  logic [3:0]  d_pend_wea;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endfunction

  // Memory model: answers m_req after fixed_lat (or random) cycles, never when muted.
  initial begin : responder
    int cnt;
    cnt = -1;
    m_bus.ready = 1'b0;
    m_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || m_bus.ready || !m_bus.req) begin
        m_bus.ready = 1'b0;
        cnt = -1;
        if (stray_req && !reset) begin
          m_bus.ready = 1'b1;
          m_bus.rdata = 32'hBAD0BAD0;
          stray_req = 1'b0;
        end
      end else if (!mute) begin
        if (cnt < 0) cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, TO - 1));
        if (cnt == 0) begin
          m_bus.ready = 1'b1;
          if (m_bus.we) begin
            mem[m_bus.addr] = merge(mem_rd(m_bus.addr), m_bus.wdata, m_bus.wea);
            m_bus.rdata = $urandom;
          end else begin
            m_bus.rdata = mem_rd(m_bus.addr);
          end
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ready pulse and checks the memory-side request.
  initial begin : monitor
    logic [31:0] a0;
    logic [4:0]  ctl0;
    bit          prev_req;
    bit          is_i, is_d;
    exp_t        e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (m_bus.req && !prev_req) begin
          a0   = m_bus.addr;
          ctl0 = {m_bus.we, m_bus.wea};
          is_i = i_pend_v && (m_bus.addr == i_pend_a) && !m_bus.we && (m_bus.wea == 4'h0);
          is_d = d_pend_v && (m_bus.addr == d_pend_a) && (m_bus.we == d_pend_we) &&
                 (!m_bus.we || ((m_bus.wea == d_pend_wea) && (m_bus.wdata == d_pend_wd)));
          checks++;
          if (!(is_i || is_d)) begin
            errors++;
            $display("FAIL m_fields: got addr %h we %b wea %h wdata %h, required a pending request",
                     m_bus.addr, m_bus.we, m_bus.wea, m_bus.wdata);
          end
          last_win = is_d ? 1 : 0;
          m_log.push_back(last_win);
        end else if (m_bus.req) begin
          check("m_stable_addr", m_bus.addr, a0);
          check("m_stable_ctl", {m_bus.we, m_bus.wea}, ctl0);
        end
        prev_req = m_bus.req;
      end
      if (i_bus.ready && d_bus.ready) check("both_ready", 1, 0);
      if (i_bus.ready) begin
        if (i_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_unexpected: got i_ready=1 rdata %h, required no pulse", i_bus.rdata);
        end else begin
          e = i_exp.pop_front();
          if (e.chk) check("i_rdata", i_bus.rdata, e.data);
        end
      end
      if (d_bus.ready) begin
        if (d_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected: got d_ready=1 rdata %h, required no pulse", d_bus.rdata);
        end else begin
          e = d_exp.pop_front();
          if (e.chk) check("d_rdata", d_bus.rdata, e.data);
        end
      end
    end
  end

  task automatic i_xfer(input logic [31:0] a, input bit zero,
                        output int rdy, output int nreq, output logic [7:0] st);
    exp_t e;
    int   n;
    n = 0; rdy = -1; nreq = 0; st = '0;
    e.data = zero ? 32'h0 : init_word(a);
    e.chk  = 1'b1;
    i_exp.push_back(e);
    i_pend_a = a; i_pend_v = 1'b1;
    i_bus.req = 1'b1; i_bus.addr = a;
    #1 st[0] = stall;
    while (rdy < 0 && n < 64) begin
      @(negedge clk);
      n++;
      if (n < 8) st[n[2:0]] = stall;
      if (m_bus.req) nreq++;
      if (i_bus.ready) rdy = n;
    end
    if (rdy < 0) begin
      checks++; errors++;
      $display("FAIL i_bound: got no i_ready in 64 cycles for addr %h, required a pulse", a);
    end
    i_bus.req = 1'b0; i_pend_v = 1'b0;
  endtask

  task automatic d_xfer(input logic we, input logic [3:0] wea, input logic [31:0] a,
                        input logic [31:0] wd, output int rdy, output int nreq);
    exp_t e;
    int   n;
    n = 0; rdy = -1; nreq = 0;
    if (we) begin
      ref_mem[a] = merge(ref_rd(a), wd, wea);
      e.data = '0; e.chk = 1'b0;
    end else begin
      e.data = ref_rd(a); e.chk = 1'b1;
    end
    d_exp.push_back(e);
    d_pend_a = a; d_pend_we = we; d_pend_wea = wea; d_pend_wd = wd; d_pend_v = 1'b1;
    d_bus.we = we; d_bus.wea = wea; d_bus.addr = a; d_bus.wdata = wd; d_bus.req = 1'b1;
    while (rdy < 0 && n < 64) begin
      @(negedge clk);
      n++;
      if (m_bus.req) nreq++;
      if (d_bus.ready) rdy = n;
    end
    if (rdy < 0) begin
      checks++; errors++;
      $display("FAIL d_bound: got no d_ready in 64 cycles for addr %h, required a pulse", a);
    end
    d_bus.req = 1'b0; d_pend_v = 1'b0;
  endtask

  initial begin : stim
    int         rdy, nr, r1, n1, r2, n2, w0;
    logic [7:0] st, s1;
    i_bus.req = 0; i_bus.we = 0; i_bus.wea = 0; i_bus.addr = 0; i_bus.wdata = 0;
    d_bus.req = 0; d_bus.we = 0; d_bus.wea = 0; d_bus.addr = 0; d_bus.wdata = 0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_m_req", m_bus.req, 0);
    check("rst_m_addr", m_bus.addr, 0);
    check("rst_m_ctl", {m_bus.we, m_bus.wea, m_bus.wdata}, 0);
    check("rst_ready", {i_bus.ready, d_bus.ready}, 0);
    check("rst_rdata", {i_bus.rdata, d_bus.rdata}, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch, memory answers in the first BUSY cycle.
    fixed_lat = 0;
    i_xfer(32'h100, 1'b0, rdy, nr, st);
    check("fetch_latency", rdy, 2);
    check("fetch_mreq_cycles", nr, 1);
    check("fetch_stall", st[2:0], 3'b011);
    check("fetch_m_addr", m_bus.addr, 32'h100);
    check("fetch_m_we", m_bus.we, 0);
    @(negedge clk);

    // Store then slow load; latency 3 makes m_ready coincide with the last allowed cycle.
    d_xfer(1'b1, 4'hF, 32'h3000, 32'h12345678, rdy, nr);
    @(negedge clk);
    fixed_lat = 3;
    d_xfer(1'b0, 4'h0, 32'h3000, 32'h0, rdy, nr);
    check("slow_latency", rdy, 5);
    check("slow_mreq_cycles", nr, 4);
    check("slow_err", err, 0);
    fixed_lat = 0;
    @(negedge clk);

    // Two ties: both requests raised in the same IDLE cycle.
`ifdef MEM_PORT_ARB_RR_EN
    w0 = 1 - last_win;
`else
    w0 = 1;
`endif
    m_log.delete();
    fork
      i_xfer(32'h180, 1'b0, r1, n1, s1);
      d_xfer(1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, r2, n2);
    join
    check("tie1_count", m_log.size(), 2);
    if (m_log.size() == 2) begin
      check("tie1_first", m_log[0], w0);
      check("tie1_second", m_log[1], 1 - w0);
    end
    @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
    w0 = 1 - last_win;
`else
    w0 = 1;
`endif
    m_log.delete();
    fork
      i_xfer(32'h184, 1'b0, r1, n1, s1);
      d_xfer(1'b0, 4'h0, 32'h2000, 32'h0, r2, n2);
    join
    check("tie2_count", m_log.size(), 2);
    if (m_log.size() == 2) check("tie2_first", m_log[0], w0);
    @(negedge clk);

    // Memory that never answers.
    mute = 1'b1;
    i_xfer(32'h200, 1'b1, rdy, nr, st);
    check("to_latency", rdy, 5);
    check("to_mreq_cycles", nr, 4);
    check("to_err_set", err, 1);
    mute = 1'b0;
    @(negedge clk);
    i_xfer(32'h204, 1'b0, rdy, nr, st);
    check("after_to_latency", rdy, 2);
    check("err_sticky", err, 1);
    @(negedge clk);

    // Reset in the second D_BUSY cycle.
    mute = 1'b1;
    d_pend_a = 32'h3000; d_pend_we = 1'b0; d_pend_wea = 4'h0; d_pend_wd = 32'h0; d_pend_v = 1'b1;
    d_bus.we = 1'b0; d_bus.wea = 4'h0; d_bus.addr = 32'h3000; d_bus.req = 1'b1;
    repeat (2) @(negedge clk);
    check("rbusy_pre_mreq", m_bus.req, 1);
    reset = 1'b1;
    #1;
    check("rbusy_async", {m_bus.req, d_bus.ready, err}, 3'b000);
    d_bus.req = 1'b0; d_pend_v = 1'b0; mute = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    i_xfer(32'h104, 1'b0, rdy, nr, st);
    check("post_rst_latency", rdy, 2);
    check("post_rst_err", err, 0);
    @(negedge clk);

    // Stray m_ready while IDLE.
    stray_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stray_quiet", {m_bus.req, i_bus.ready, d_bus.ready}, 3'b000);
    i_xfer(32'h108, 1'b0, rdy, nr, st);
    check("stray_latency", rdy, 2);
    @(negedge clk);

    // Random concurrent traffic with random memory latency.
    fixed_lat = -1;
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          i_xfer(32'h400 + ($urandom_range(0, 255) << 2), 1'b0, r1, n1, s1);
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 1) == 1)
            d_xfer(1'b1, 4'($urandom_range(1, 15)), 32'h1000_0000 + ($urandom_range(0, 15) << 2),
                   $urandom, r2, n2);
          else
            d_xfer(1'b0, 4'h0, 32'h1000_0000 + ($urandom_range(0, 15) << 2), 32'h0, r2, n2);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("end_i_queue", i_exp.size(), 0);
    check("end_d_queue", d_exp.size(), 0);
    check("end_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_time: got no completion by 2ms, required finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported memory between the pipelined CPU's instruction-fetch stage and its MEM-stage data access.
- Serialises the two requesters onto one memory handshake (`MIO_ready`-style ready pulse) and returns read data to the owning requester.
- Drives the pipeline stall while any request is outstanding, and aborts a memory that never answers with a watchdog timeout.
- Sits between the CPU's IM/DM ports and the shared memory/MIO bus.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of BUSY cycles before abort. Must be ≥1.
- `CNT_W`, default 8: watchdog counter width. `TIMEOUT` must be < 2^`CNT_W`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `i_req`  in  1: instruction fetch request. Held until `i_ready`.
- `i_addr`  in  32: fetch address.
- `i_rdata`  out  32: fetched word. Valid while `i_ready`=1.
- `i_ready`  out  1: one-cycle completion pulse for fetch.
- `d_req`  in  1: data request. Held until `d_ready`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_wea`  in  4: byte write enables.
- `d_addr`  in  32: data address.
- `d_wdata`  in  32: store data.
- `d_rdata`  out  32: load data. Valid while `d_ready`=1.
- `d_ready`  out  1: one-cycle completion pulse for data.
- `m_req`  out  1: memory request. Held through BUSY.
- `m_we`  out  1: memory write.
- `m_wea`  out  4: memory byte enables.
- `m_addr`  out  32: memory address.
- `m_wdata`  out  32: memory write data.
- `m_rdata`  in  32: memory read data. Valid with `m_ready`.
- `m_ready`  in  1: memory completion pulse.
- `stall`  out  1: pipeline hold.
- `err`  out  1: sticky timeout flag.

## Operation
States:
- IDLE: samples requests and picks a grant.
  - No request: stay in IDLE.
  - Only one request: grant that requester.
  - Both requests: data wins (see Configuration). Go to I_BUSY or D_BUSY.
  - On the transition, register `m_addr`/`m_we`/`m_wea`/`m_wdata` from the winner.
  - For a fetch grant, `m_we`=0 and `m_wea`=0.
- I_BUSY / D_BUSY:
  - `m_req`=1 and all `m_*` outputs stay stable.
  - On `m_ready`=1: capture `m_rdata` into the return register and go to I_DONE / D_DONE.
- I_DONE / D_DONE:
  - Assert `i_ready` or `d_ready` for exactly one cycle, with the captured data. `m_req`=0.
  - Always return to IDLE. Requests are not sampled in DONE.
- Timeout abort:
  - Watchdog counter clears on entry to BUSY and increments each BUSY cycle that has no `m_ready`.
  - If the count equals `TIMEOUT`-1 and `m_ready`=0: go to DONE with return data 0x00000000 and set `err`.
- `stall` is combinational: `(i_req & ~i_ready) | (d_req & ~d_ready)`.
- Stores also pass through DONE; `d_rdata` is then don't-care but is driven with the captured `m_rdata`.
- `last_grant` register records the most recent winner. Reset value = instruction.

## Timing
- Reset: asserting `reset` forces, immediately and asynchronously:
  - IDLE state;
  - all `m_*` outputs, `i_ready`, `d_ready`, `i_rdata`, `d_rdata` = 0;
  - watchdog counter = 0, `err` = 0, `last_grant` = instruction.
- Reset mid-BUSY abandons the transfer silently; no ready pulse is issued.
- Latency, with a request first seen in IDLE at cycle 0:
  - `m_req` rises at cycle 1.
  - With `m_ready` in cycle 1+k, the ready pulse is at cycle 2+k.
  - IDLE again at cycle 3+k. Minimum is 3 cycles per transfer.
- Requester handshake:
  - Keep the request and its fields stable until the ready edge.
  - On that edge, either drop the request or present the next one; it is sampled in the following IDLE.
- Boundary conditions:
  - `m_ready` and timeout in the same cycle: `m_ready` wins; data is captured and `err` is unchanged.
  - `m_ready` in IDLE or DONE is ignored.
  - A `TIMEOUT`=1 abort holds `m_req` for exactly 1 cycle.
  - `err` stays 1 until `reset`; later transfers proceed normally.

## Configuration
Macro `MEM_PORT_ARB_RR_EN`:
- Defined: when both requests are pending in IDLE, grant the requester that is not `last_grant` (round-robin).
- Undefined: data always wins a tie; `last_grant` is still maintained but unused.

## Structure
- Shared header `mem_arb_defs.v` holds:
  - state encodings (IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE, 3 bits);
  - grant IDs (`GRANT_I`=0, `GRANT_D`=1).
- One sub-module, `mem_arb_watchdog`:
  - holds the `CNT_W`-bit counter;
  - inputs: clear, enable, `m_ready`;
  - output: `expire` = (count==`TIMEOUT`-1) & ~`m_ready` & enable.

## Test plan
- Lone fetch:
  - Stimulus: `i_req`=1, `i_addr`=0x100; memory answers `m_ready` in first BUSY cycle with 0x00500093.
  - Response: `m_addr`=0x100 at cycle 1; `i_ready` pulse at cycle 2 with `i_rdata`=0x00500093; `stall`=1 in cycles 0–1; `m_we`=0.
- Tie, macro undefined:
  - Stimulus: `i_req` and store (`d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wea`=4'b1111) both pending.
  - Response: store is served first (`m_we`=1, `m_wea`=4'hF), then the fetch.
  - With `MEM_PORT_ARB_RR_EN` defined, the next tie grants the fetch first.
- Slow memory:
  - Stimulus: load at 0x3000, `m_ready` delayed 3 cycles, data 0x12345678.
  - Response: `d_ready` at cycle 5, `d_rdata`=0x12345678, `m_req` high for cycles 1–4.
- Timeout:
  - Stimulus: `TIMEOUT`=4, `m_ready` never asserted.
  - Response: `m_req` high exactly 4 cycles; ready pulse with rdata 0; `err`=1 and stays 1 through later successful transfers.
- Reset mid-BUSY:
  - Stimulus: assert `reset` in cycle 2 of a D_BUSY.
  - Response: `m_req`, `d_ready`, `err` all 0 without waiting for a clock edge; a new fetch after release completes in 3 cycles.
- Stray `m_ready`:
  - Stimulus: pulse `m_ready` while IDLE.
  - Response: no state change, no ready pulses.
